// File: rtl/vending_pkg.sv
// Shared encodings for the vending controller: FSM states, status codes
// and coin values in nickel units.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_ACCEPT   = 3'd0,
        ST_DISPENSE = 3'd1,
        ST_CHANGE   = 3'd2,
        ST_ERROR    = 3'd3,
        ST_RESTOCK  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        STAT_IDLE     = 3'd0,
        STAT_CREDIT   = 3'd1,
        STAT_DISPENSE = 3'd2,
        STAT_CHANGE   = 3'd3,
        STAT_SOLD_OUT = 3'd4,
        STAT_NO_FUNDS = 3'd5,
        STAT_BAD_SEL  = 3'd6,
        STAT_RESTOCK  = 3'd7
    } status_t;

    localparam int NICKEL  = 1;
    localparam int DIME    = 2;
    localparam int QUARTER = 5;

endpackage

// File: rtl/inventory_bank.sv
// Per-item stock counters: decrement one item, load all items with a value,
// read one item by index and flag the empty ones.
module inventory_bank
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 3,
    parameter int STOCK_INIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_dec,
    input  logic [SEL_W-1:0]     i_dec_idx,
    input  logic                 i_load,
    input  logic [STOCK_W-1:0]   i_load_val,
    input  logic [SEL_W-1:0]     i_rd_idx,
    output logic [STOCK_W-1:0]   o_rd_stock,
    output logic [NUM_ITEMS-1:0] o_sold_out
);

    logic [STOCK_W-1:0] r_stock [NUM_ITEMS];

    // Counter update: load-all has priority over a decrement; an empty counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (i_load) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= i_load_val;
        end else if (i_dec) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (int'(i_dec_idx) == i && r_stock[i] != '0) r_stock[i] <= r_stock[i] - 1'b1;
            end
        end
    end

    // Indexed read (out-of-range index reads as empty) and the empty flags.
    always_comb begin
        o_rd_stock = '0;
        o_sold_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(i_rd_idx) == i) o_rd_stock = r_stock[i];
            o_sold_out[i] = (r_stock[i] == '0);
        end
    end

endmodule

// File: rtl/vending_core.sv
// N-item vending controller: credit accumulation with a ceiling, purchase
// checks, timed dispense, greedy coin-by-coin change and restock mode.
//
// state       | meaning
// ST_ACCEPT   | taking coins, waiting for confirm/cancel/restock
// ST_DISPENSE | driving the one-hot vend output for DISP_TICKS ticks
// ST_CHANGE   | returning credit one coin per tick, largest first
// ST_ERROR    | showing a purchase error for ERR_TICKS ticks, coins still taken
// ST_RESTOCK  | stock reloaded to STOCK_MAX, waiting for restock to drop
module vending_core
    import vending_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            SEL_W      = 2,
    parameter int                            CREDIT_W   = 6,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {6'd7, 6'd5, 6'd4, 6'd3},
    parameter int                            MAX_CREDIT = 20,
    parameter int                            STOCK_W    = 3,
    parameter int                            STOCK_INIT = 3,
    parameter int                            STOCK_MAX  = 7,
    parameter int                            DISP_TICKS = 2,
    parameter int                            ERR_TICKS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_tick,
    input  logic                 i_coin_nickel,
    input  logic                 i_coin_dime,
    input  logic                 i_coin_quarter,
    input  logic                 i_btn_confirm,
    input  logic                 i_btn_cancel,
    input  logic [SEL_W-1:0]     i_item_sel,
    input  logic                 i_restock,
    output logic [CREDIT_W-1:0]  o_credit,
    output logic [NUM_ITEMS-1:0] o_dispense,
    output logic                 o_change_nickel,
    output logic                 o_change_dime,
    output logic                 o_change_quarter,
    output logic                 o_coin_reject,
    output logic [2:0]           o_status,
    output logic [NUM_ITEMS-1:0] o_sold_out,
    output logic                 o_busy
);

    localparam int TICK_MAX = (DISP_TICKS > ERR_TICKS) ? DISP_TICKS : ERR_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    state_t              r_state, w_state_nxt;
    status_t             r_err, w_err_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [TICK_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic                r_chg_n, r_chg_d, r_chg_q, w_chg_n, w_chg_d, w_chg_q;
    logic                r_coin_reject, w_coin_reject;
    logic [1:0]          r_rej_pend, w_rej_pend, w_rej_new, w_rej_low, w_coin_cnt;
    logic [2:0]          w_rej_total, w_rej_left;
    logic [CREDIT_W-1:0] w_coin_val, w_price;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_any, w_coin_fits, w_sel_ok, w_dec, w_load;
    logic [STOCK_W-1:0]  w_stock;

    inventory_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .SEL_W      (SEL_W),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT)
    ) u_inv (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_dec      (w_dec),
        .i_dec_idx  (i_item_sel),
        .i_load     (w_load),
        .i_load_val (STOCK_W'(STOCK_MAX)),
        .i_rd_idx   (i_item_sel),
        .o_rd_stock (w_stock),
        .o_sold_out (o_sold_out)
    );

    assign w_coin_any  = i_coin_quarter | i_coin_dime | i_coin_nickel;
    assign w_coin_cnt  = {1'b0, i_coin_quarter} + {1'b0, i_coin_dime} + {1'b0, i_coin_nickel};
    assign w_sum       = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_fits = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign w_sel_ok    = (int'(i_item_sel) < NUM_ITEMS);

    // Coin priority decode (quarter > dime > nickel) and price lookup for the selection.
    always_comb begin
        w_coin_val = '0;
        w_rej_low  = '0;
        if (i_coin_quarter) begin
            w_coin_val = CREDIT_W'(QUARTER);
            w_rej_low  = {1'b0, i_coin_dime} + {1'b0, i_coin_nickel};
        end else if (i_coin_dime) begin
            w_coin_val = CREDIT_W'(DIME);
            w_rej_low  = {1'b0, i_coin_nickel};
        end else if (i_coin_nickel) begin
            w_coin_val = CREDIT_W'(NICKEL);
        end
        w_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(i_item_sel) == i) w_price = PRICES[i*CREDIT_W +: CREDIT_W];
        end
    end

    // Next-state, credit, timer and change-pulse decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_err_nxt    = r_err;
        w_dec        = 1'b0;
        w_load       = 1'b0;
        w_chg_n      = 1'b0;
        w_chg_d      = 1'b0;
        w_chg_q      = 1'b0;
        w_rej_new    = '0;
        case (r_state)
            ST_ACCEPT, ST_ERROR: begin
                if (w_coin_any) begin
                    w_rej_new = w_rej_low + (w_coin_fits ? 2'd0 : 2'd1);
                    if (w_coin_fits) w_credit_nxt = w_sum[CREDIT_W-1:0];
                end
                if (r_state == ST_ERROR) begin
                    if (i_tick) begin
                        if (r_cnt <= TICK_W'(1)) w_state_nxt = ST_ACCEPT;
                        else w_cnt_nxt = r_cnt - 1'b1;
                    end
                end else if (!w_coin_any) begin
                    if (i_restock && r_credit == '0) begin
                        w_state_nxt = ST_RESTOCK;
                        w_load      = 1'b1;
                    end else if (i_btn_cancel) begin
                        if (r_credit != '0) w_state_nxt = ST_CHANGE;
                    end else if (i_btn_confirm) begin
                        w_cnt_nxt = TICK_W'(ERR_TICKS);
                        if (!w_sel_ok) begin
                            w_state_nxt = ST_ERROR;
                            w_err_nxt   = STAT_BAD_SEL;
                        end else if (w_stock == '0) begin
                            w_state_nxt = ST_ERROR;
                            w_err_nxt   = STAT_SOLD_OUT;
                        end else if (r_credit < w_price) begin
                            w_state_nxt = ST_ERROR;
                            w_err_nxt   = STAT_NO_FUNDS;
                        end else begin
                            w_state_nxt  = ST_DISPENSE;
                            w_credit_nxt = r_credit - w_price;
                            w_dec        = 1'b1;
                            w_sel_nxt    = i_item_sel;
                            w_cnt_nxt    = TICK_W'(DISP_TICKS);
                        end
                    end
                end
            end
            ST_DISPENSE: begin
                w_rej_new = w_coin_cnt;
                if (i_tick) begin
                    if (r_cnt <= TICK_W'(1)) w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_ACCEPT;
                    else w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_CHANGE: begin
                w_rej_new = w_coin_cnt;
                if (r_credit == '0) begin
                    w_state_nxt = ST_ACCEPT;
                end else if (i_tick) begin
                    if (r_credit >= CREDIT_W'(QUARTER)) begin
                        w_chg_q      = 1'b1;
                        w_credit_nxt = r_credit - CREDIT_W'(QUARTER);
                    end else if (r_credit >= CREDIT_W'(DIME)) begin
                        w_chg_d      = 1'b1;
                        w_credit_nxt = r_credit - CREDIT_W'(DIME);
                    end else begin
                        w_chg_n      = 1'b1;
                        w_credit_nxt = r_credit - CREDIT_W'(NICKEL);
                    end
                    if (w_credit_nxt == '0) w_state_nxt = ST_ACCEPT;
                end
            end
            ST_RESTOCK: begin
                w_rej_new = w_coin_cnt;
                if (!i_restock) w_state_nxt = ST_ACCEPT;
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // Several refused coins in one cycle become separate reject pulses with a gap between them.
    always_comb begin
        w_rej_total   = {1'b0, r_rej_pend} + {1'b0, w_rej_new};
        w_rej_left    = w_rej_total;
        w_coin_reject = 1'b0;
        if (!r_coin_reject && w_rej_total != 3'd0) begin
            w_coin_reject = 1'b1;
            w_rej_left    = w_rej_total - 3'd1;
        end
        w_rej_pend = (w_rej_left > 3'd3) ? 2'd3 : w_rej_left[1:0];
    end

    // State register and registered datapath/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ACCEPT;
            r_err         <= STAT_IDLE;
            r_credit      <= '0;
            r_cnt         <= '0;
            r_sel         <= '0;
            r_chg_n       <= 1'b0;
            r_chg_d       <= 1'b0;
            r_chg_q       <= 1'b0;
            r_coin_reject <= 1'b0;
            r_rej_pend    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_err         <= w_err_nxt;
            r_credit      <= w_credit_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sel         <= w_sel_nxt;
            r_chg_n       <= w_chg_n;
            r_chg_d       <= w_chg_d;
            r_chg_q       <= w_chg_q;
            r_coin_reject <= w_coin_reject;
            r_rej_pend    <= w_rej_pend;
        end
    end

    // Status, busy and vend output decoded from the registered state.
    always_comb begin
        o_status   = STAT_IDLE;
        o_busy     = 1'b0;
        o_dispense = '0;
        case (r_state)
            ST_ACCEPT:   o_status = (r_credit == '0) ? STAT_IDLE : STAT_CREDIT;
            ST_DISPENSE: begin
                o_status = STAT_DISPENSE;
                o_busy   = 1'b1;
                for (int i = 0; i < NUM_ITEMS; i++) o_dispense[i] = (int'(r_sel) == i);
            end
            ST_CHANGE: begin
                o_status = STAT_CHANGE;
                o_busy   = 1'b1;
            end
            ST_ERROR:    o_status = r_err;
            ST_RESTOCK: begin
                o_status = STAT_RESTOCK;
                o_busy   = 1'b1;
            end
            default:     o_status = STAT_IDLE;
        endcase
    end

    assign o_credit         = r_credit;
    assign o_change_nickel  = r_chg_n;
    assign o_change_dime    = r_chg_d;
    assign o_change_quarter = r_chg_q;
    assign o_coin_reject    = r_coin_reject;

endmodule
